// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory, one transaction in flight at a time.
// Define ARB_PERF_EN to add the perf_conflict / perf_if_stall counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned AW       = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [1:0]    dm_size,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ack,
  output logic [31:0]   dm_rdata,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_if_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_r, state_nxt_s;
  logic [7:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic        grant_if_s, grant_dm_s;
  logic [31:0] if_rdata_r, dm_rdata_r;

  // Next-state, arbitration and acknowledge decode
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    grant_if_s     = 1'b0;
    grant_dm_s     = 1'b0;
    if_ack         = 1'b0;
    dm_ack         = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && (!dm_req || (wait_cnt_r == MAX_WAIT_C))) begin
          grant_if_s     = 1'b1;
          state_nxt_s    = BUSY_IF;
          wait_cnt_nxt_s = 8'd0;
        end else if (dm_req) begin
          grant_dm_s  = 1'b1;
          state_nxt_s = BUSY_DM;
          // fetch lost this arbitration: age it towards forced priority
          if (if_req && (wait_cnt_r < MAX_WAIT_C)) begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          if_ack      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY_IF;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          dm_ack      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY_DM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if_rdata = if_ack ? mem_rdata : if_rdata_r;
    dm_rdata = dm_ack ? mem_rdata : dm_rdata_r;
  end

  assign busy    = (state_r != IDLE);
  assign mem_req = busy;

  // FSM state and fetch starvation counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Memory-side request fields, captured from the winner at grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else if (grant_if_s) begin
      mem_we    <= 1'b0;
      mem_size  <= 2'd2;
      mem_addr  <= if_addr;
      mem_wdata <= 32'd0;
    end else if (grant_dm_s) begin
      mem_we    <= dm_we;
      mem_size  <= dm_size;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end
  end

  // Read data holding registers, refreshed on each acknowledge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata_r <= 32'd0;
      dm_rdata_r <= 32'd0;
    end else begin
      if (if_ack) begin
        if_rdata_r <= mem_rdata;
      end
      if (dm_ack) begin
        dm_rdata_r <= mem_rdata;
      end
    end
  end

`ifdef ARB_PERF_EN
  // Wrapping performance counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_conflict <= 32'd0;
      perf_if_stall <= 32'd0;
    end else begin
      if ((state_r == IDLE) && if_req && dm_req) begin
        perf_conflict <= perf_conflict + 32'd1;
      end
      if (if_req && !if_ack) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle
// plus directed scenarios (lone fetch, collision, starvation, reset mid-op, stray ack, perf).
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int AW       = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [1:0]    dm_size;
  logic [31:0]   dm_wdata, mem_rdata;
  logic          if_ack, dm_ack, busy, mem_req, mem_we;
  logic [31:0]   if_rdata, dm_rdata, mem_wdata;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_conflict, perf_if_stall;
`endif

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_if_stall(perf_if_stall)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // model: owner 0=none 1=fetch 2=data
  int          m_owner, m_wait;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd, m_conf, m_stall;

  // bench-side requester / memory state
  int   lat, rcnt, cyc, if_acks, dm_acks;
  logic stray, if_hold, dm_hold, if_seen, dm_seen;
  int   ack_log[$];
  int   ack_cyc[$];
  int   dm_at_if[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_we = 1'b0; m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
    m_if_rd = 32'd0; m_dm_rd = 32'd0; m_conf = 32'd0; m_stall = 32'd0;
  endtask

  // applies the arbitration rules at a rising edge
  task automatic model_step();
    bit if_wins;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_owner == 0 && if_req && dm_req) m_conf = m_conf + 32'd1;
    if (if_req && !(m_owner == 1 && mem_ack)) m_stall = m_stall + 32'd1;
    if (m_owner == 0) begin
      if (if_req || dm_req) begin
        if_wins = if_req && (!dm_req || m_wait >= MAX_WAIT);
        if (if_wins) begin
          m_owner = 1; m_wait = 0;
          m_we = 1'b0; m_size = 2'd2; m_addr = if_addr; m_wdata = 32'd0;
        end else begin
          m_owner = 2;
          m_we = dm_we; m_size = dm_size; m_addr = dm_addr; m_wdata = dm_wdata;
          if (if_req) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        end
      end
    end else if (mem_ack) begin
      if (m_owner == 1) m_if_rd = mem_rdata;
      else m_dm_rd = mem_rdata;
      m_owner = 0;
    end
  endtask

  task automatic monitor();
    logic e_busy, e_if_ack, e_dm_ack;
    e_busy   = (m_owner != 0);
    e_if_ack = (m_owner == 1) && mem_ack;
    e_dm_ack = (m_owner == 2) && mem_ack;
    chk("busy", busy, e_busy);
    chk("mem_req", mem_req, e_busy);
    chk("if_ack", if_ack, e_if_ack);
    chk("dm_ack", dm_ack, e_dm_ack);
    chk("if_rdata", if_rdata, e_if_ack ? mem_rdata : m_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_ack ? mem_rdata : m_dm_rd);
    chk("mem_we", mem_we, m_we);
    chk("mem_size", mem_size, m_size);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
`ifdef ARB_PERF_EN
    chk("perf_conflict_m", perf_conflict, m_conf);
    chk("perf_if_stall_m", perf_if_stall, m_stall);
`endif
    if (if_ack) begin
      dm_at_if.push_back(dm_acks);
      if_acks++; if_seen = 1'b1; ack_log.push_back(1); ack_cyc.push_back(cyc);
    end
    if (dm_ack) begin
      dm_acks++; dm_seen = 1'b1; ack_log.push_back(2); ack_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  // memory model: acks after lat waiting cycles, read data = addr ^ A5A50000
  task automatic respond();
    if (mem_ack) begin
      mem_ack = 1'b0; rcnt = 0; mem_rdata = $urandom;
    end else if (mem_req) begin
      if (rcnt >= lat) begin
        mem_ack = 1'b1; mem_rdata = mem_addr ^ 32'hA5A5_0000;
      end else begin
        rcnt++; mem_rdata = $urandom;
      end
    end else begin
      rcnt = 0; mem_ack = stray; mem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    model_step();
    #1;
    respond();
    if (!if_hold && if_seen) if_req = 1'b0;
    if (!dm_hold && dm_seen) dm_req = 1'b0;
    if_seen = 1'b0;
    dm_seen = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_acks(input int want_if, input int want_dm, input int budget, input string nm);
    int n;
    n = 0;
    while ((if_acks < want_if || dm_acks < want_dm) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, (if_acks >= want_if && dm_acks >= want_dm), 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    if_req = 1'b0; dm_req = 1'b0; stray = 1'b0; if_hold = 1'b0; dm_hold = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int i0, d0;
    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0;
    if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    stray = 1'b0; if_hold = 1'b0; dm_hold = 1'b0; if_seen = 1'b0; dm_seen = 1'b0;
    lat = 0; rcnt = 0; cyc = 0; if_acks = 0; dm_acks = 0;
    model_reset();

    // reset state
    ticks(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: lone fetch, memory acks two cycles after mem_req rises
    lat = 2; i0 = if_acks; if_addr = 32'h0000_0100; if_req = 1'b1;
    tick();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h0000_0100);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_size", mem_size, 2'd2);
    wait_acks(i0 + 1, 0, 20, "t1_timeout");
    ticks(3);
    chk("t1_ack_count", if_acks - i0, 1);
    chk("t1_if_rdata", if_rdata, 32'hA5A5_0100);

    // 2: collision, store wins, fetch after a one-cycle bubble
    lat = 1; i0 = if_acks; d0 = dm_acks; ack_log.delete(); ack_cyc.delete();
    if_addr = 32'h0000_0104; dm_addr = 32'h0000_2000; dm_wdata = 32'hDEAD_BEEF;
    dm_we = 1'b1; dm_size = 2'd2; if_req = 1'b1; dm_req = 1'b1;
    tick();
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_addr", mem_addr, 32'h0000_2000);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_acks(i0 + 1, d0 + 1, 30, "t2_timeout");
    chk("t2_n_acks", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("t2_first_dm", ack_log[0], 2);
      chk("t2_second_if", ack_log[1], 1);
      chk("t2_gap", ack_cyc[1] - ack_cyc[0], 3);
    end
    ticks(2);
    chk("t2_dm_rdata", dm_rdata, 32'hA5A5_2000);

    // 3: starvation guard, fetch wins the 9th arbitration and the count restarts
    do_reset();
    lat = 0; dm_at_if.delete(); d0 = dm_acks; i0 = if_acks;
    dm_we = 1'b0; dm_addr = 32'h0000_3000; if_addr = 32'h0000_0200;
    if_hold = 1'b1; dm_hold = 1'b1; if_req = 1'b1; dm_req = 1'b1;
    wait_acks(i0 + 2, 0, 200, "t3_timeout");
    if (dm_at_if.size() >= 2) begin
      chk("t3_first_grant", dm_at_if[0] - d0, 8);
      chk("t3_second_grant", dm_at_if[1] - dm_at_if[0], 8);
    end else begin
      chk("t3_if_grants", dm_at_if.size(), 2);
    end
    if_hold = 1'b0; dm_hold = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    ticks(4);

    // 4: reset during a data transaction
    lat = 10; d0 = dm_acks; dm_we = 1'b1; dm_addr = 32'h0000_4000; dm_req = 1'b1;
    ticks(2);
    chk("t4_busy_before", busy, 1'b1);
    #2;
    reset_n = 1'b0; model_reset(); dm_req = 1'b0;
    #1;
    chk("t4_mem_req_now", mem_req, 1'b0);
    chk("t4_dm_ack_now", dm_ack, 1'b0);
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    chk("t4_idle_after", busy, 1'b0);
    chk("t4_no_ack", dm_acks - d0, 0);

    // 5: stray mem_ack in IDLE, then a fetch dropped while in flight
    i0 = if_acks; d0 = dm_acks;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    ticks(3);
    chk("t5_stray_if", if_acks - i0, 0);
    chk("t5_stray_dm", dm_acks - d0, 0);
    lat = 3; if_addr = 32'h0000_0300; if_req = 1'b1;
    ticks(2);
    if_req = 1'b0;
    wait_acks(i0 + 1, 0, 20, "t5_timeout");
    ticks(4);
    chk("t5_one_ack", if_acks - i0, 1);
    chk("t5_if_rdata", if_rdata, 32'hA5A5_0300);
    chk("t5_idle", busy, 1'b0);

`ifdef ARB_PERF_EN
    // 6: five collision arbitrations
    do_reset();
    lat = 0; dm_we = 1'b0; dm_addr = 32'h0000_0040; if_addr = 32'h0000_0500;
    if_hold = 1'b1; dm_hold = 1'b1; if_req = 1'b1; dm_req = 1'b1;
    ticks(9);
    chk("t6_perf_conflict", perf_conflict, 32'd5);
    if_hold = 1'b0; dm_hold = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    ticks(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
